// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline datapath and pipe_ctrl.
// The master side is the datapath/fetch unit; the slave side is the controller.
interface pipe_ctrl_if #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic            id_is_load;
    logic            ex_redirect;
    logic            mem_busy;

    logic            if_hold;
    logic            pc_redirect;
    logic [3:0]      stage_valid;
    logic [XLEN-1:0] ex_pc;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [63:0]     retire_cnt;
    logic [63:0]     stall_cnt;

    modport master (
        output if_valid, if_pc, id_rs1, id_rs2, id_rd, id_is_load, ex_redirect, mem_busy,
        input  if_hold, pc_redirect, stage_valid, ex_pc, fwd_a_sel, fwd_b_sel,
        input  retire_cnt, stall_cnt
    );

    modport slave (
        input  if_valid, if_pc, id_rs1, id_rs2, id_rd, id_is_load, ex_redirect, mem_busy,
        output if_hold, pc_redirect, stage_valid, ex_pc, fwd_a_sel, fwd_b_sel,
        output retire_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard, stall, redirect and forwarding control for an IF/ID/EX/MEM/WB pipeline.
// Optional PIPE_PERF_EN builds the retire/stall performance counters.
module pipe_ctrl #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_LOAD_USE,
        MODE_REDIRECT,
        MODE_MEM_BUSY
    } mode_e;

    // Per-stage bookkeeping; decoder fields arrive with the fetched instruction.
    logic            id_valid, ex_valid, mem_valid, wb_valid;
    logic [XLEN-1:0] id_pc, ex_pc_r, mem_pc, wb_pc;
    logic [RA_W-1:0] id_rd, ex_rd, mem_rd, wb_rd;
    logic            id_is_load, ex_is_load, mem_is_load, wb_is_load;
    logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2;

    logic            id_valid_n, ex_valid_n, mem_valid_n, wb_valid_n;
    logic [XLEN-1:0] id_pc_n, ex_pc_n, mem_pc_n, wb_pc_n;
    logic [RA_W-1:0] id_rd_n, ex_rd_n, mem_rd_n, wb_rd_n;
    logic            id_is_load_n, ex_is_load_n, mem_is_load_n, wb_is_load_n;
    logic [RA_W-1:0] id_rs1_n, id_rs2_n, ex_rs1_n, ex_rs2_n;

    logic  load_use;
    logic  redirect;
    mode_e mode;

    assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                      ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));
    assign redirect = ex_valid & bus.ex_redirect & ~bus.mem_busy;

    always_comb begin
        mode = MODE_RUN;
        if (bus.mem_busy)  mode = MODE_MEM_BUSY;
        else if (redirect) mode = MODE_REDIRECT;
        else if (load_use) mode = MODE_LOAD_USE;
    end

    assign bus.if_hold     = bus.mem_busy | (load_use & ~redirect);
    assign bus.pc_redirect = redirect;
    assign bus.stage_valid = {wb_valid, mem_valid, ex_valid, id_valid};
    assign bus.ex_pc       = ex_pc_r;

    // MEM beats WB; invalid stages and x0 never forward.
    always_comb begin
        bus.fwd_a_sel = 2'b00;
        if (mem_valid && mem_rd != '0 && mem_rd == ex_rs1)
            bus.fwd_a_sel = 2'b01;
        else if (wb_valid && wb_rd != '0 && wb_rd == ex_rs1)
            bus.fwd_a_sel = 2'b10;
    end

    always_comb begin
        bus.fwd_b_sel = 2'b00;
        if (mem_valid && mem_rd != '0 && mem_rd == ex_rs2)
            bus.fwd_b_sel = 2'b01;
        else if (wb_valid && wb_rd != '0 && wb_rd == ex_rs2)
            bus.fwd_b_sel = 2'b10;
    end

    // Bubbles only clear valid; the other fields of a killed stage are kept.
    always_comb begin
        id_valid_n   = id_valid;   id_pc_n   = id_pc;    id_rd_n   = id_rd;
        id_is_load_n = id_is_load; id_rs1_n  = id_rs1;   id_rs2_n  = id_rs2;
        ex_valid_n   = ex_valid;   ex_pc_n   = ex_pc_r;  ex_rd_n   = ex_rd;
        ex_is_load_n = ex_is_load; ex_rs1_n  = ex_rs1;   ex_rs2_n  = ex_rs2;
        mem_valid_n  = mem_valid;  mem_pc_n  = mem_pc;   mem_rd_n  = mem_rd;
        mem_is_load_n = mem_is_load;
        wb_valid_n   = wb_valid;   wb_pc_n   = wb_pc;    wb_rd_n   = wb_rd;
        wb_is_load_n = wb_is_load;

        if (mode == MODE_MEM_BUSY) begin
            wb_valid_n = 1'b0;
        end else begin
            wb_valid_n    = mem_valid;  wb_pc_n  = mem_pc;
            wb_rd_n       = mem_rd;     wb_is_load_n = mem_is_load;
            mem_valid_n   = ex_valid;   mem_pc_n = ex_pc_r;
            mem_rd_n      = ex_rd;      mem_is_load_n = ex_is_load;
            unique case (mode)
                MODE_REDIRECT: begin
                    id_valid_n = 1'b0;
                    ex_valid_n = 1'b0;
                end
                MODE_LOAD_USE: begin
                    ex_valid_n = 1'b0;
                end
                default: begin
                    ex_valid_n   = id_valid;     ex_pc_n  = id_pc;
                    ex_rd_n      = id_rd;        ex_is_load_n = id_is_load;
                    ex_rs1_n     = id_rs1;       ex_rs2_n = id_rs2;
                    id_valid_n   = bus.if_valid; id_pc_n  = bus.if_pc;
                    id_rd_n      = bus.id_rd;    id_is_load_n = bus.id_is_load;
                    id_rs1_n     = bus.id_rs1;   id_rs2_n = bus.id_rs2;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            id_valid  <= 1'b0; id_pc   <= '0; id_rd  <= '0; id_is_load  <= 1'b0;
            id_rs1    <= '0;   id_rs2  <= '0;
            ex_valid  <= 1'b0; ex_pc_r <= '0; ex_rd  <= '0; ex_is_load  <= 1'b0;
            ex_rs1    <= '0;   ex_rs2  <= '0;
            mem_valid <= 1'b0; mem_pc  <= '0; mem_rd <= '0; mem_is_load <= 1'b0;
            wb_valid  <= 1'b0; wb_pc   <= '0; wb_rd  <= '0; wb_is_load  <= 1'b0;
        end else begin
            id_valid  <= id_valid_n;  id_pc   <= id_pc_n;  id_rd  <= id_rd_n;
            id_is_load <= id_is_load_n;
            id_rs1    <= id_rs1_n;    id_rs2  <= id_rs2_n;
            ex_valid  <= ex_valid_n;  ex_pc_r <= ex_pc_n;  ex_rd  <= ex_rd_n;
            ex_is_load <= ex_is_load_n;
            ex_rs1    <= ex_rs1_n;    ex_rs2  <= ex_rs2_n;
            mem_valid <= mem_valid_n; mem_pc  <= mem_pc_n; mem_rd <= mem_rd_n;
            mem_is_load <= mem_is_load_n;
            wb_valid  <= wb_valid_n;  wb_pc   <= wb_pc_n;  wb_rd  <= wb_rd_n;
            wb_is_load <= wb_is_load_n;
        end
    end

    // WB pc and load flag are kept for debug visibility but drive no output.
    logic unused_wb;
    assign unused_wb = ^{wb_pc, wb_is_load};

`ifdef PIPE_PERF_EN
    logic [63:0] retire_cnt_r;
    logic [63:0] stall_cnt_r;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            retire_cnt_r <= '0;
            stall_cnt_r  <= '0;
        end else begin
            if (wb_valid)    retire_cnt_r <= retire_cnt_r + 64'd1;
            if (bus.if_hold) stall_cnt_r  <= stall_cnt_r + 64'd1;
        end
    end

    assign bus.retire_cnt = retire_cnt_r;
    assign bus.stall_cnt  = stall_cnt_r;
`else
    assign bus.retire_cnt = 64'd0;
    assign bus.stall_cnt  = 64'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: flow, load-use, redirect, mem_busy priority,
// forwarding and asynchronous reset.
module tb_pipe_ctrl;

`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic sys_clk;
    logic sys_rst;
    int   checks;
    int   errors;

    pipe_ctrl_if #(.XLEN(64), .RA_W(5)) bus ();

    pipe_ctrl #(.XLEN(64), .RA_W(5)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_in;
        bus.if_valid    = 1'b0;
        bus.if_pc       = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
        bus.id_is_load  = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.mem_busy    = 1'b0;
    endtask

    task automatic feed(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ld);
        bus.if_valid   = 1'b1;
        bus.if_pc      = pc;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_rd      = rd;
        bus.id_is_load = ld;
    endtask

    task automatic do_reset;
        sys_rst = 1'b0;
        idle_in();
        tick();
        tick();
        sys_rst = 1'b1;
    endtask

    task automatic test_reset;
        idle_in();
        sys_rst = 1'b0;
        #3;
        checks++;
        if (bus.stage_valid !== 4'b0000 || bus.ex_pc !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: stage_valid=%b ex_pc=%h expected 0000/0", bus.stage_valid, bus.ex_pc);
        end
        checks++;
        if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00 || bus.pc_redirect !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: fwd_a=%b fwd_b=%b pc_redirect=%b expected 00/00/0",
                     bus.fwd_a_sel, bus.fwd_b_sel, bus.pc_redirect);
        end
        tick();
        checks++;
        if (bus.retire_cnt !== 64'd0 || bus.stall_cnt !== 64'd0) begin
            errors++;
            $display("FAIL reset_cnt: retire=%0d stall=%0d expected 0/0", bus.retire_cnt, bus.stall_cnt);
        end
        sys_rst = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [3:0] sv_tab [9];
        sv_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111,
                   4'b1110, 4'b1100, 4'b1000, 4'b0000};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 5) feed(64'h8000_0000 + 64'(4 * i), 5'd0, 5'd0, 5'(i + 1), 1'b0);
            else       idle_in();
            tick();
            checks++;
            if (bus.stage_valid !== sv_tab[i]) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: got %b expected %b", i, bus.stage_valid, sv_tab[i]);
            end
            if (i >= 1 && i <= 5) begin
                checks++;
                if (bus.ex_pc !== 64'h8000_0000 + 64'(4 * (i - 1))) begin
                    errors++;
                    $display("FAIL b2b_ex_pc[%0d]: got %h expected %h", i, bus.ex_pc,
                             64'h8000_0000 + 64'(4 * (i - 1)));
                end
            end
        end
        checks++;
        if (bus.retire_cnt !== (PERF ? 64'd5 : 64'd0) || bus.stall_cnt !== 64'd0) begin
            errors++;
            $display("FAIL b2b_counters: retire=%0d stall=%0d expected %0d/0",
                     bus.retire_cnt, bus.stall_cnt, PERF ? 5 : 0);
        end
    endtask

    task automatic test_load_use;
        do_reset();
        feed(64'h100, 5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        feed(64'h104, 5'd0, 5'd5, 5'd6, 1'b0);
        tick();
        feed(64'h108, 5'd0, 5'd0, 5'd8, 1'b0);
        #1;
        checks++;
        if (bus.if_hold !== 1'b1 || bus.stage_valid !== 4'b0011) begin
            errors++;
            $display("FAIL lu_hold: if_hold=%b stage_valid=%b expected 1/0011", bus.if_hold, bus.stage_valid);
        end
        tick();
        checks++;
        if (bus.if_hold !== 1'b0 || bus.stage_valid !== 4'b0101) begin
            errors++;
            $display("FAIL lu_bubble: if_hold=%b stage_valid=%b expected 0/0101", bus.if_hold, bus.stage_valid);
        end
        checks++;
        if (bus.stall_cnt !== (PERF ? 64'd1 : 64'd0)) begin
            errors++;
            $display("FAIL lu_stall_cnt: got %0d expected %0d", bus.stall_cnt, PERF ? 1 : 0);
        end
        tick();
        checks++;
        if (bus.fwd_b_sel !== 2'b10 || bus.fwd_a_sel !== 2'b00 || bus.ex_pc !== 64'h104) begin
            errors++;
            $display("FAIL lu_forward: fwd_b=%b fwd_a=%b ex_pc=%h expected 10/00/104",
                     bus.fwd_b_sel, bus.fwd_a_sel, bus.ex_pc);
        end
        checks++;
        if (bus.stage_valid !== 4'b1011) begin
            errors++;
            $display("FAIL lu_after: stage_valid=%b expected 1011", bus.stage_valid);
        end
    endtask

    task automatic test_redirect;
        do_reset();
        feed(64'h200, 5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        feed(64'h204, 5'd5, 5'd0, 5'd6, 1'b0);
        tick();
        feed(64'h208, 5'd0, 5'd0, 5'd7, 1'b0);
        bus.ex_redirect = 1'b1;
        #1;
        checks++;
        if (bus.pc_redirect !== 1'b1 || bus.if_hold !== 1'b0) begin
            errors++;
            $display("FAIL redir_assert: pc_redirect=%b if_hold=%b expected 1/0", bus.pc_redirect, bus.if_hold);
        end
        tick();
        bus.ex_redirect = 1'b0;
        feed(64'h400, 5'd0, 5'd0, 5'd9, 1'b0);
        #1;
        checks++;
        if (bus.stage_valid !== 4'b0100 || bus.pc_redirect !== 1'b0) begin
            errors++;
            $display("FAIL redir_bubbles: stage_valid=%b pc_redirect=%b expected 0100/0",
                     bus.stage_valid, bus.pc_redirect);
        end
        tick();
        idle_in();
        checks++;
        if (bus.stage_valid !== 4'b1001) begin
            errors++;
            $display("FAIL redir_target_id: stage_valid=%b expected 1001", bus.stage_valid);
        end
        tick();
        checks++;
        if (bus.stage_valid !== 4'b0010 || bus.ex_pc !== 64'h400) begin
            errors++;
            $display("FAIL redir_target_ex: stage_valid=%b ex_pc=%h expected 0010/400",
                     bus.stage_valid, bus.ex_pc);
        end
    endtask

    task automatic test_busy_redirect;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            feed(64'h300 + 64'(4 * i), 5'd0, 5'd0, 5'(i + 1), 1'b0);
            tick();
        end
        feed(64'h310, 5'd0, 5'd0, 5'd5, 1'b0);
        bus.ex_redirect = 1'b1;
        bus.mem_busy    = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.pc_redirect !== 1'b0 || bus.if_hold !== 1'b1) begin
                errors++;
                $display("FAIL busy_ctrl[%0d]: pc_redirect=%b if_hold=%b expected 0/1",
                         k, bus.pc_redirect, bus.if_hold);
            end
            tick();
            checks++;
            if (bus.stage_valid !== 4'b0111 || bus.ex_pc !== 64'h308) begin
                errors++;
                $display("FAIL busy_hold[%0d]: stage_valid=%b ex_pc=%h expected 0111/308",
                         k, bus.stage_valid, bus.ex_pc);
            end
        end
        bus.mem_busy = 1'b0;
        #1;
        checks++;
        if (bus.pc_redirect !== 1'b1 || bus.if_hold !== 1'b0) begin
            errors++;
            $display("FAIL busy_release: pc_redirect=%b if_hold=%b expected 1/0", bus.pc_redirect, bus.if_hold);
        end
        checks++;
        if (bus.stall_cnt !== (PERF ? 64'd3 : 64'd0) || bus.retire_cnt !== (PERF ? 64'd1 : 64'd0)) begin
            errors++;
            $display("FAIL busy_counters: stall=%0d retire=%0d expected %0d/%0d",
                     bus.stall_cnt, bus.retire_cnt, PERF ? 3 : 0, PERF ? 1 : 0);
        end
        tick();
        bus.ex_redirect = 1'b0;
        checks++;
        if (bus.stage_valid !== 4'b1100) begin
            errors++;
            $display("FAIL busy_redirect: stage_valid=%b expected 1100", bus.stage_valid);
        end
    endtask

    task automatic test_forward;
        logic [4:0] rd0_tab [4];
        logic [4:0] rd1_tab [4];
        logic [4:0] rs1_tab [4];
        logic [1:0] exp_tab [4];
        rd0_tab = '{5'd7, 5'd0, 5'd7, 5'd3};
        rd1_tab = '{5'd7, 5'd0, 5'd3, 5'd7};
        rs1_tab = '{5'd7, 5'd0, 5'd7, 5'd7};
        exp_tab = '{2'b01, 2'b00, 2'b10, 2'b01};
        for (int v = 0; v < 4; v++) begin
            do_reset();
            feed(64'h500, 5'd0, 5'd0, rd0_tab[v], 1'b0);
            tick();
            feed(64'h504, 5'd0, 5'd0, rd1_tab[v], 1'b0);
            tick();
            feed(64'h508, rs1_tab[v], 5'd0, 5'd9, 1'b0);
            tick();
            idle_in();
            tick();
            checks++;
            if (bus.fwd_a_sel !== exp_tab[v] || bus.fwd_b_sel !== 2'b00) begin
                errors++;
                $display("FAIL fwd[%0d]: fwd_a=%b fwd_b=%b expected %b/00",
                         v, bus.fwd_a_sel, bus.fwd_b_sel, exp_tab[v]);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        feed(64'h600, 5'd0, 5'd0, 5'd7, 1'b0);
        tick();
        feed(64'h604, 5'd0, 5'd0, 5'd3, 1'b0);
        tick();
        feed(64'h608, 5'd7, 5'd0, 5'd9, 1'b0);
        tick();
        idle_in();
        tick();
        bus.ex_redirect = 1'b1;
        #1;
        checks++;
        if (bus.pc_redirect !== 1'b1 || bus.fwd_a_sel !== 2'b10 || bus.stage_valid !== 4'b1110) begin
            errors++;
            $display("FAIL arst_pre: pc_redirect=%b fwd_a=%b stage_valid=%b expected 1/10/1110",
                     bus.pc_redirect, bus.fwd_a_sel, bus.stage_valid);
        end
        #1;
        sys_rst = 1'b0;
        #1;
        checks++;
        if (bus.stage_valid !== 4'b0000 || bus.ex_pc !== 64'd0 || bus.pc_redirect !== 1'b0 ||
            bus.if_hold !== 1'b0) begin
            errors++;
            $display("FAIL arst_outputs: stage_valid=%b ex_pc=%h pc_redirect=%b if_hold=%b expected all 0",
                     bus.stage_valid, bus.ex_pc, bus.pc_redirect, bus.if_hold);
        end
        checks++;
        if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00 ||
            bus.retire_cnt !== 64'd0 || bus.stall_cnt !== 64'd0) begin
            errors++;
            $display("FAIL arst_fwd_cnt: fwd_a=%b fwd_b=%b retire=%0d stall=%0d expected all 0",
                     bus.fwd_a_sel, bus.fwd_b_sel, bus.retire_cnt, bus.stall_cnt);
        end
        tick();
        idle_in();
        sys_rst = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        sys_rst = 1'b0;
        idle_in();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_redirect();
        test_busy_redirect();
        test_forward();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
